hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/sat_counter.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcode constants used by the ID-stage
// hazard logic and the hazard controller FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // RUN: normal issue; STALL2: second bubble of a load feeding a branch.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_STALL2 = 1'b1
  } hz_state_e;

  // A producer register r conflicts with the ID instruction when it is not x0
  // and matches a source field that the instruction actually reads.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2,
                                     input logic       uses_rs1,
                                     input logic       uses_rs2);
    return (r != 5'd0) && ((uses_rs1 && (r == rs1)) || (uses_rs2 && (r == rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline event statistics.
// Ports: clk, reset (async, active-high), inc (count enable),
//        count (current value, holds at all-ones).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection and stall/flush control.
// Inputs: IF/ID opcode and source fields, ID/EX and EX/MEM destination and
//         load/write flags, ID-stage branch resolution (Br_taken).
// Outputs: Pc_wr, Ifid_wr, Idex_bubble, Ifid_flush (combinational, same cycle),
//          Stall_cnt / Flush_cnt saturating statistics, State_o FSM debug.
module hazard_stall_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode_fo,
  input  logic [4:0]       Rs1_fo,
  input  logic [4:0]       Rs2_fo,
  input  logic [4:0]       Rd_do,
  input  logic             Reg_wr_do,
  input  logic             Mem_rd_do,
  input  logic [4:0]       Rd_eo,
  input  logic             Mem_rd_eo,
  input  logic             Br_taken,
  output logic             Pc_wr,
  output logic             Ifid_wr,
  output logic             Idex_bubble,
  output logic             Ifid_flush,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt,
  output logic             State_o
);

  hz_state_e state_q;
  hz_state_e state_d;

  logic uses_rs1;
  logic uses_rs2;
  logic is_br;
  logic haz_h1;
  logic haz_h2;
  logic haz_h3;
  logic stall;
  logic flush;

  always_comb begin
    uses_rs1 = !((Opcode_fo == OP_LUI) || (Opcode_fo == OP_AUIPC) || (Opcode_fo == OP_JAL));
    uses_rs2 = (Opcode_fo == OP_RTYPE) || (Opcode_fo == OP_STORE) || (Opcode_fo == OP_BRANCH);
    is_br    = (Opcode_fo == OP_BRANCH);
  end

  always_comb begin
    haz_h1 = Mem_rd_do && reg_match(Rd_do, Rs1_fo, Rs2_fo, uses_rs1, uses_rs2);
    haz_h2 = Reg_wr_do && !Mem_rd_do && is_br &&
             reg_match(Rd_do, Rs1_fo, Rs2_fo, uses_rs1, uses_rs2);
    haz_h3 = Mem_rd_eo && is_br && reg_match(Rd_eo, Rs1_fo, Rs2_fo, uses_rs1, uses_rs2);
  end

  // Reset forces the stall pattern on the outputs; counters are held clear by
  // their own async reset, so the stall seen here during reset is never counted.
  always_comb begin
    state_d = ST_RUN;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = haz_h1 || haz_h2 || haz_h3;
        if (haz_h1 && is_br) begin
          state_d = ST_STALL2;
        end
      end
      ST_STALL2: begin
        stall   = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        stall   = 1'b1;
        state_d = ST_RUN;
      end
    endcase
    if (reset) begin
      stall = 1'b1;
    end
    flush = !stall && Br_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign Pc_wr       = !stall;
  assign Ifid_wr     = !stall;
  assign Idex_bubble = stall;
  assign Ifid_flush  = flush;
  assign State_o     = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (Stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (Flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MAXC = '1;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    Opcode_fo;
  logic [4:0]    Rs1_fo, Rs2_fo, Rd_do, Rd_eo;
  logic          Reg_wr_do, Mem_rd_do, Mem_rd_eo, Br_taken;
  logic          Pc_wr, Ifid_wr, Idex_bubble, Ifid_flush, State_o;
  logic [CW-1:0] Stall_cnt, Flush_cnt;

  hazard_stall_ctrl #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode_fo   (Opcode_fo),
    .Rs1_fo      (Rs1_fo),
    .Rs2_fo      (Rs2_fo),
    .Rd_do       (Rd_do),
    .Reg_wr_do   (Reg_wr_do),
    .Mem_rd_do   (Mem_rd_do),
    .Rd_eo       (Rd_eo),
    .Mem_rd_eo   (Mem_rd_eo),
    .Br_taken    (Br_taken),
    .Pc_wr       (Pc_wr),
    .Ifid_wr     (Ifid_wr),
    .Idex_bubble (Idex_bubble),
    .Ifid_flush  (Ifid_flush),
    .Stall_cnt   (Stall_cnt),
    .Flush_cnt   (Flush_cnt),
    .State_o     (State_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [4:0]    ctl;   // {Pc_wr, Ifid_wr, Idex_bubble, Ifid_flush, State_o}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic          m_st;
  logic [CW-1:0] m_sc, m_fc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic mt(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b,
                              input logic ua, input logic ub);
    if (r == 5'd0) return 1'b0;
    return (ua && r == a) || (ub && r == b);
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rdd, input logic rwd, input logic mrd,
                       input logic [4:0] rde, input logic mre, input logic br);
    Opcode_fo = op;  Rs1_fo = rs1;   Rs2_fo = rs2;
    Rd_do     = rdd; Reg_wr_do = rwd; Mem_rd_do = mrd;
    Rd_eo     = rde; Mem_rd_eo = mre; Br_taken = br;
  endtask

  task automatic drive_idle();
    drive(T_ITYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rdd, input logic rwd,
                      input logic mrd, input logic [4:0] rde, input logic mre,
                      input logic br);
    logic u1, u2, isbr, h1, h2, h3, stl, fl;
    exp_t e;
    @(posedge clk);
    #1;
    drive(op, rs1, rs2, rdd, rwd, mrd, rde, mre, br);
    u1   = !(op == T_LUI || op == T_AUIPC || op == T_JAL);
    u2   = (op == T_RTYPE || op == T_STORE || op == T_BRANCH);
    isbr = (op == T_BRANCH);
    h1   = mrd && mt(rdd, rs1, rs2, u1, u2);
    h2   = rwd && !mrd && isbr && mt(rdd, rs1, rs2, u1, u2);
    h3   = mre && isbr && mt(rde, rs1, rs2, u1, u2);
    stl  = m_st || h1 || h2 || h3;
    fl   = !stl && br;
    e.tag = tag;
    e.ctl = {!stl, !stl, stl, fl, m_st};
    e.sc  = m_sc;
    e.fc  = m_fc;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".ctl"}, {27'd0, Pc_wr, Ifid_wr, Idex_bubble, Ifid_flush, State_o},
                {27'd0, e.ctl});
      check_val({e.tag, ".scnt"}, 32'(Stall_cnt), 32'(e.sc));
      check_val({e.tag, ".fcnt"}, 32'(Flush_cnt), 32'(e.fc));
    end
    if (stl && m_sc != MAXC) m_sc = m_sc + 1'b1;
    if (fl && m_fc != MAXC)  m_fc = m_fc + 1'b1;
    m_st = !m_st && h1 && isbr;
  endtask

  task automatic step_idle(input string tag);
    step(tag, T_ITYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, ".ctl"}, {27'd0, Pc_wr, Ifid_wr, Idex_bubble, Ifid_flush, State_o},
              32'b00100);
    check_val({tag, ".scnt"}, 32'(Stall_cnt), 32'd0);
    check_val({tag, ".fcnt"}, 32'(Flush_cnt), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_idle();
    #2;
    check_reset_outs(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_st = 1'b0;
    m_sc = '0;
    m_fc = '0;
  endtask

  initial begin
    drive_idle();
    m_st = 1'b0;
    m_sc = '0;
    m_fc = '0;
    #3;
    check_reset_outs("por");

    // load x5 in EX, add x6,x5,x1 in ID
    apply_reset("rst1");
    step("lu_add", T_RTYPE, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step_idle("lu_add_after");
    check_val("lu_add.scnt_abs", 32'(Stall_cnt), 32'd1);
    check_val("lu_add.state_abs", 32'(State_o), 32'd0);

    // load x5 in EX, beq x5,x0 in ID: two bubbles, taken branch suppressed
    apply_reset("rst2");
    step("lb_s1", T_BRANCH, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    step("lb_s2", T_BRANCH, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    step_idle("lb_run");
    check_val("lb.scnt_abs", 32'(Stall_cnt), 32'd2);
    check_val("lb.fcnt_abs", 32'(Flush_cnt), 32'd0);
    check_val("lb.state_abs", 32'(State_o), 32'd0);

    // STALL2 ignores inputs entirely
    apply_reset("rst2b");
    step("lb2_s1", T_BRANCH, 5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step_idle("lb2_s2_idle_in");
    step("lb2_run_br", T_BRANCH, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    // add x7 in EX, bne x0,x7 in ID, then taken
    apply_reset("rst3");
    step("ab_stall", T_BRANCH, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step("ab_taken", T_BRANCH, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1);
    check_val("ab.flush_abs", 32'(Ifid_flush), 32'd1);
    step_idle("ab_after");
    check_val("ab.fcnt_abs", 32'(Flush_cnt), 32'd1);
    check_val("ab.scnt_abs", 32'(Stall_cnt), 32'd1);

    // x0 and non-reading opcodes never hazard
    apply_reset("rst4");
    step("x0_load", T_RTYPE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    check_val("x0_load.pcwr_abs", 32'(Pc_wr), 32'd1);
    step("lui_load", T_LUI, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("jal_load", T_JAL, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step("itype_rs2", T_ITYPE, 5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("store_rs2", T_STORE, 5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("alu_nonbr", T_RTYPE, 5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step("h3_rd0", T_BRANCH, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("h3_rs2", T_BRANCH, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    step_idle("x0_after");

    // reset pulsed while in STALL2
    apply_reset("rst5");
    step("rp_s1", T_BRANCH, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_val("rp.in_stall2", 32'(State_o), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outs("rp.async");
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_st = 1'b0;
    m_sc = '0;
    m_fc = '0;
    step_idle("rp_release");
    check_val("rp.pcwr_abs", 32'(Pc_wr), 32'd1);

    // saturation of a 4-bit stall counter
    apply_reset("rst6");
    for (int i = 0; i < 20; i++) begin
      step("sat", T_RTYPE, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    end
    step_idle("sat_after");
    check_val("sat.scnt_abs", 32'(Stall_cnt), 32'd15);

    // random traffic against the model
    apply_reset("rst7");
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0: op = T_LOAD;
        1: op = T_ITYPE;
        2: op = T_RTYPE;
        3: op = T_STORE;
        4: op = T_BRANCH;
        5: op = T_LUI;
        6: op = T_AUIPC;
        default: op = T_JAL;
      endcase
      step("rnd", op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step_idle("rnd_after");
    check_val("sb.drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
